multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Sequencing FSM that lets the existing ARM-subset datapath run one instruction over several cycles, sharing a single ALU and a unified memory port.
- Decodes the latched instruction fields, evaluates the condition code against a flags register it owns, and steps through fetch/decode/execute/memory/writeback states.
- Drives every datapath mux select and write enable.
- Sits between the instruction register and the multicycle datapath.

Parameters:
- STATE_W, 4, width of the state register (eleven states used).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- Cond  in  4  Instr[31:28]
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]
- Rd  in  4  Instr[15:12]
- ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0=PC, 1=ALU result register
- MemW  out  1  data memory write enable
- IRWrite  out  1  instruction register enable
- RegW  out  1  register file write enable
- ResultSrc  out  2  00=ALUOut reg, 01=Data reg, 10=ALU result direct
- ALUSrcA  out  1  0=register A, 1=PC
- ALUSrcB  out  2  00=register WD, 01=ExtImm, 10=constant 4
- ALUControl  out  4  ALU command (ADD=0100, SUB=0010, AND=0000, ORR=1100, CMP=1010, MOV=1101)
- ImmSrc  out  2  = Op
- RegSrc  out  2  {Op==01, Op==10}
- Illegal  out  1  one-cycle pulse on undefined opcode
- State  out  STATE_W  current state, for debug

Behaviour:
- Reset:
  - State <= FETCH; flags <= 0000; cond_ok <= 0.
  - All write enables (PCWrite, MemW, IRWrite, RegW) are forced 0 while reset=1.
  - Reset asserted mid-instruction abandons it with no further writes.
- Outputs are a Moore decode of state. Write enables in post-DECODE states are gated by the registered cond_ok.
- FETCH:
  - Asserts IRWrite and PCWrite; AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=0100, ResultSrc=10.
  - Next state: DECODE.
- DECODE:
  - ALUSrcA=1, ALUSrcB=10, ALUControl=0100 (PC+8 into ALUOut).
  - cond_ok <= condition check of Cond against the flags register (EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL; 1111 is treated as AL).
  - Next state:
    - Op=00, Funct[5]=0: EXECUTER
    - Op=00, Funct[5]=1: EXECUTEI
    - Op=01: MEMADR
    - Op=10: BRANCH
    - Op=11: FETCH, with Illegal pulsed in this cycle
- EXECUTER / EXECUTEI:
  - ALUSrcA=0, ALUSrcB=00 (EXECUTER) or 01 (EXECUTEI); ALUControl=Funct[4:1].
  - Flags update on this edge only if cond_ok and S=Funct[0]=1:
    - NZ always written.
    - CV written only for ADD/SUB/CMP.
    - CMP writes all four flags regardless of S.
  - Next state: ALUWB.
- ALUWB:
  - ResultSrc=00; RegW=cond_ok & (cmd!=CMP).
  - If Rd==1111 and RegW, PCWrite=1 as well (PC-relative write).
  - Next state: FETCH.
- MEMADR:
  - ALUSrcA=0, ALUSrcB=01, ALUControl=0100.
  - Next state: MEMREAD if Funct[0]=1 (LDR), else MEMWRITE.
- MEMREAD: AdrSrc=1; next state MEMWB.
- MEMWB: ResultSrc=01; RegW=cond_ok; PCWrite if Rd==1111; next state FETCH.
- MEMWRITE: AdrSrc=1; MemW=cond_ok; next state FETCH.
- BRANCH:
  - ALUSrcA=0 (register A = PC+8 via RegSrc), ALUSrcB=01, ALUControl=0100, ResultSrc=10.
  - PCWrite=cond_ok.
  - Next state: FETCH.
- Latency in cycles: branch 3, data-processing 4, STR 4, LDR 5, illegal 2.
- A failed condition still walks the full state sequence with all enables suppressed, so cycle count does not depend on the flags.
- Unused state encodings return to FETCH on the next edge with no writes.

Optional Feature:
- MC_BX_EN
  - Defined: Op=00 with Funct=010010 (BX Rm) goes DECODE -> BRANCHX. BRANCHX sets ALUSrcA=0, ALUSrcB=00, ALUControl=1101 (MOV Rm), ResultSrc=10, PCWrite=cond_ok, then goes to FETCH (3 cycles).
  - Undefined: that encoding is an ordinary register data-processing instruction, and BRANCHX does not exist.

Decomposition:
- Shared package mc_pkg holds:
  - state enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, BRANCHX)
  - condition-code constants
  - ALU command constants
  - ResultSrc/ALUSrcB select constants
- One sub-module, mc_cond_unit, contains the flags register, the update enables and the condition evaluation. The FSM stays in the top module.

Test Plan:
- Reset held 2 cycles mid-LDR (state MEMREAD), then released -> State=FETCH, no RegW/MemW pulse, flags=0000.
- ADDS R1,R2,R3 (Cond=1110, Op=00, Funct=001001) with ALUFlags=0100 -> 4 cycles; RegW=1 in ALUWB only; flags=0100 afterwards.
- CMP sets Z, then BEQ (Cond=0000, Op=10) -> BRANCH asserts PCWrite. Repeat with Z=0 -> PCWrite=0 and still 3 cycles.
- LDR (Op=01, Funct=011001) -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB; AdrSrc=1 in MEMREAD; ResultSrc=01 with RegW=1 in MEMWB.
- STR with Cond=NE and Z=1 -> MEMWRITE reached, MemW=0. Op=11 -> Illegal=1 for one cycle, back in FETCH after 2 cycles.
- MOV PC,R4 (Rd=1111) -> ALUWB asserts RegW=1 and PCWrite=1. With MC_BX_EN, BX R4 -> BRANCHX, PCWrite=1, ALUControl=1101.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle controller and its condition unit.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        BRANCHX  = 4'd10
    } state_e;

    localparam logic [3:0] CondEq = 4'b0000;
    localparam logic [3:0] CondNe = 4'b0001;
    localparam logic [3:0] CondCs = 4'b0010;
    localparam logic [3:0] CondCc = 4'b0011;
    localparam logic [3:0] CondMi = 4'b0100;
    localparam logic [3:0] CondPl = 4'b0101;
    localparam logic [3:0] CondVs = 4'b0110;
    localparam logic [3:0] CondVc = 4'b0111;
    localparam logic [3:0] CondHi = 4'b1000;
    localparam logic [3:0] CondLs = 4'b1001;
    localparam logic [3:0] CondGe = 4'b1010;
    localparam logic [3:0] CondLt = 4'b1011;
    localparam logic [3:0] CondGt = 4'b1100;
    localparam logic [3:0] CondLe = 4'b1101;
    localparam logic [3:0] CondAl = 4'b1110;

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b0010;
    localparam logic [3:0] AluAdd = 4'b0100;
    localparam logic [3:0] AluCmp = 4'b1010;
    localparam logic [3:0] AluOrr = 4'b1100;
    localparam logic [3:0] AluMov = 4'b1101;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluDirect = 2'b10;

    localparam logic [1:0] SrcBReg  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [5:0] FunctBx = 6'b010010;

endpackage

// File: rtl/mc_cond_unit.sv
// Flags register, flag-update enables and condition-code evaluation.
module mc_cond_unit
    import mc_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       latch_i,
    input  logic       exec_i,
    input  logic [3:0] cond_i,
    input  logic [3:0] cmd_i,
    input  logic       s_i,
    input  logic [3:0] alu_flags_i,
    output logic       cond_ok_o,
    output logic [3:0] flags_o
);

    logic [3:0] flags_q, flags_d;
    logic       cond_ok_q, cond_ok_d;
    logic       n, z, c, v;
    logic       cond_pass;
    logic       is_cmp, upd_nz, upd_cv;

    assign {n, z, c, v} = flags_q;

    always_comb begin
        cond_pass = 1'b1;
        case (cond_i)
            CondEq:  cond_pass = z;
            CondNe:  cond_pass = ~z;
            CondCs:  cond_pass = c;
            CondCc:  cond_pass = ~c;
            CondMi:  cond_pass = n;
            CondPl:  cond_pass = ~n;
            CondVs:  cond_pass = v;
            CondVc:  cond_pass = ~v;
            CondHi:  cond_pass = c & ~z;
            CondLs:  cond_pass = ~c | z;
            CondGe:  cond_pass = (n == v);
            CondLt:  cond_pass = (n != v);
            CondGt:  cond_pass = ~z & (n == v);
            CondLe:  cond_pass = z | (n != v);
            default: cond_pass = 1'b1;
        endcase
    end

    // CMP exists only to set flags, so it writes all four even without S.
    assign is_cmp = (cmd_i == AluCmp);
    assign upd_nz = exec_i & cond_ok_q & (s_i | is_cmp);
    assign upd_cv = upd_nz & (is_cmp | (cmd_i == AluAdd) | (cmd_i == AluSub));

    always_comb begin
        flags_d   = flags_q;
        cond_ok_d = cond_ok_q;
        if (upd_nz) flags_d[3:2] = alu_flags_i[3:2];
        if (upd_cv) flags_d[1:0] = alu_flags_i[1:0];
        if (latch_i) cond_ok_d = cond_pass;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            flags_q   <= 4'b0000;
            cond_ok_q <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            cond_ok_q <= cond_ok_d;
        end
    end

    assign cond_ok_o = cond_ok_q;
    assign flags_o   = flags_q;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle sequencing FSM for the ARM-subset datapath.
// Define MC_BX_EN to add the BX Rm instruction (BRANCHX state).
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         Cond,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic [3:0]         Rd,
    input  logic [3:0]         ALUFlags,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemW,
    output logic               IRWrite,
    output logic               RegW,
    output logic [1:0]         ResultSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [3:0]         ALUControl,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         RegSrc,
    output logic               Illegal,
    output logic [STATE_W-1:0] State
);

    state_e     state_q, state_d;
    logic       cond_ok;
    logic [3:0] flags;
    logic [3:0] cmd;
    logic       pcw, irw, regw, memw;

    assign cmd = Funct[4:1];

    mc_cond_unit u_cond (
        .clk_i       (clk),
        .reset_i     (reset),
        .latch_i     (state_q == DECODE),
        .exec_i      ((state_q == EXECUTER) || (state_q == EXECUTEI)),
        .cond_i      (Cond),
        .cmd_i       (cmd),
        .s_i         (Funct[0]),
        .alu_flags_i (ALUFlags),
        .cond_ok_o   (cond_ok),
        .flags_o     (flags)
    );

    always_comb begin
        state_d    = FETCH;
        pcw        = 1'b0;
        irw        = 1'b0;
        regw       = 1'b0;
        memw       = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = ResAluOut;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SrcBReg;
        ALUControl = AluAdd;
        Illegal    = 1'b0;
        case (state_q)
            FETCH: begin
                irw       = 1'b1;
                pcw       = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SrcBFour;
                ResultSrc = ResAluDirect;
                state_d   = DECODE;
            end
            DECODE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SrcBFour;
                unique case (Op)
                    2'b00: begin
                        state_d = Funct[5] ? EXECUTEI : EXECUTER;
`ifdef MC_BX_EN
                        if (Funct == FunctBx) state_d = BRANCHX;
`endif
                    end
                    2'b01: state_d = MEMADR;
                    2'b10: state_d = BRANCH;
                    2'b11: begin
                        state_d = FETCH;
                        Illegal = 1'b1;
                    end
                endcase
            end
            EXECUTER: begin
                ALUSrcB    = SrcBReg;
                ALUControl = cmd;
                state_d    = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcB    = SrcBImm;
                ALUControl = cmd;
                state_d    = ALUWB;
            end
            ALUWB: begin
                ResultSrc = ResAluOut;
                regw      = cond_ok & (cmd != AluCmp);
                pcw       = cond_ok & (cmd != AluCmp) & (Rd == 4'hF);
            end
            MEMADR: begin
                ALUSrcB = SrcBImm;
                state_d = Funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = ResData;
                regw      = cond_ok;
                pcw       = cond_ok & (Rd == 4'hF);
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                memw   = cond_ok;
            end
            BRANCH: begin
                ALUSrcB   = SrcBImm;
                ResultSrc = ResAluDirect;
                pcw       = cond_ok;
            end
`ifdef MC_BX_EN
            BRANCHX: begin
                ALUSrcB    = SrcBReg;
                ALUControl = AluMov;
                ResultSrc  = ResAluDirect;
                pcw        = cond_ok;
            end
`endif
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Reset abandons an in-flight instruction, so no write may escape while it is held.
    assign PCWrite = pcw & ~reset;
    assign IRWrite = irw & ~reset;
    assign RegW    = regw & ~reset;
    assign MemW    = memw & ~reset;

    assign ImmSrc = Op;
    assign RegSrc = {Op == 2'b01, Op == 2'b10};
    assign State  = STATE_W'(state_q);

endmodule
